// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the 16-bit pipelined core's memory-access stage:
//   LOAD / STORE    opcodes that start a data-memory transaction
//   REG_IDX_W       width of a register-file index
//   CTRL_W          width of the opcode/control bundle
//   ma_state_t      MA stage FSM states (IDLE, WAIT)
//   is_mem_op()     true for opcodes that need a memory transaction
// -----------------------------------------------------------------------------
package pipeline_pkg;

   localparam int REG_IDX_W = 5;
   localparam int CTRL_W    = 5;

   localparam logic [CTRL_W-1:0] LOAD  = 5'b01100;
   localparam logic [CTRL_W-1:0] STORE = 5'b01101;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } ma_state_t;

   function automatic logic is_mem_op(input logic [CTRL_W-1:0] ctrl);
      return (ctrl == LOAD) || (ctrl == STORE);
   endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// -----------------------------------------------------------------------------
// memory_access_stage_if
// Request/acknowledge bus between the MA stage and data memory.
//   MEM_REQ    stage -> mem   request held high for the whole transaction
//   MEM_WE     stage -> mem   1 = store, 0 = load
//   MEM_ADDR   stage -> mem   word address
//   MEM_WDATA  stage -> mem   store data
//   MEM_RDATA  mem -> stage   load data, valid in the MEM_ACK cycle
//   MEM_ACK    mem -> stage   one-cycle completion pulse
// Handshake: a transaction starts when MEM_REQ rises; MEM_WE, MEM_ADDR and
// MEM_WDATA stay stable while MEM_REQ is high; the transfer completes in the
// cycle MEM_ACK is sampled high while MEM_REQ is high, and MEM_REQ drops in the
// following cycle. MEM_ACK while MEM_REQ is low carries no meaning.
// -----------------------------------------------------------------------------
interface memory_access_stage_if #(
   parameter int DATA_W = 16
);
   logic              MEM_REQ;
   logic              MEM_WE;
   logic [DATA_W-1:0] MEM_ADDR;
   logic [DATA_W-1:0] MEM_WDATA;
   logic [DATA_W-1:0] MEM_RDATA;
   logic              MEM_ACK;

   modport master (
      output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
      input  MEM_RDATA, MEM_ACK
   );

   modport slave (
      input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
      output MEM_RDATA, MEM_ACK
   );
endinterface

// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
// MA stage between EX and write-back. Non-memory instructions pass straight
// into the MA pipeline register; LOAD/STORE are held while a request/ack
// transaction runs on the memory bus, stalling EX until it completes or
// times out.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   VALID_EX .. CTRL_EX      instruction presented by EX
//   STALL_MA                 EX must hold its outputs (high in WAIT)
//   mem                      data-memory bus (master side)
//   MEM_ERR                  sticky timeout flag, cleared only by rst
//   *_MA                     registered bundle to write-back
//   state_dbg                current FSM state
// -----------------------------------------------------------------------------
module memory_access_stage
   import pipeline_pkg::*;
#(
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst,

   input  logic                 VALID_EX,
   input  logic [REG_IDX_W-1:0] DEST_REG_INDEX_EX,
   input  logic                 DEST_REG_WRITE_EN_EX,
   input  logic [DATA_W-1:0]    RES_EX,
   input  logic [DATA_W-1:0]    STORE_DATA_EX,
   input  logic [CTRL_W-1:0]    CTRL_EX,

   output logic                 STALL_MA,

   memory_access_stage_if.master mem,

   output logic                 MEM_ERR,

   output logic [REG_IDX_W-1:0] DEST_REG_INDEX_MA,
   output logic                 DEST_REG_WRITE_EN_MA,
   output logic [DATA_W-1:0]    RES_MA,
   output logic [DATA_W-1:0]    DATA_MA,
   output logic [CTRL_W-1:0]    CTRL_MA,

   output ma_state_t            state_dbg
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   // Value the counter holds in the last permitted WAIT cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   ma_state_t            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 err_q, err_d;

   // Memory instruction held for the duration of the transaction.
   logic [REG_IDX_W-1:0] hold_idx_q, hold_idx_d;
   logic                 hold_we_q, hold_we_d;
   logic [DATA_W-1:0]    hold_res_q, hold_res_d;
   logic [DATA_W-1:0]    hold_wdata_q, hold_wdata_d;
   logic [CTRL_W-1:0]    hold_ctrl_q, hold_ctrl_d;

   // MA pipeline register.
   logic [REG_IDX_W-1:0] ma_idx_q, ma_idx_d;
   logic                 ma_we_q, ma_we_d;
   logic [DATA_W-1:0]    ma_res_q, ma_res_d;
   logic [DATA_W-1:0]    ma_data_q, ma_data_d;
   logic [CTRL_W-1:0]    ma_ctrl_q, ma_ctrl_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         hold_idx_q   <= '0;
         hold_we_q    <= 1'b0;
         hold_res_q   <= '0;
         hold_wdata_q <= '0;
         hold_ctrl_q  <= '0;
         ma_idx_q     <= '0;
         ma_we_q      <= 1'b0;
         ma_res_q     <= '0;
         ma_data_q    <= '0;
         ma_ctrl_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         hold_idx_q   <= hold_idx_d;
         hold_we_q    <= hold_we_d;
         hold_res_q   <= hold_res_d;
         hold_wdata_q <= hold_wdata_d;
         hold_ctrl_q  <= hold_ctrl_d;
         ma_idx_q     <= ma_idx_d;
         ma_we_q      <= ma_we_d;
         ma_res_q     <= ma_res_d;
         ma_data_q    <= ma_data_d;
         ma_ctrl_q    <= ma_ctrl_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      hold_idx_d   = hold_idx_q;
      hold_we_d    = hold_we_q;
      hold_res_d   = hold_res_q;
      hold_wdata_d = hold_wdata_q;
      hold_ctrl_d  = hold_ctrl_q;
      ma_idx_d     = ma_idx_q;
      ma_we_d      = ma_we_q;
      ma_res_d     = ma_res_q;
      ma_data_d    = ma_data_q;
      ma_ctrl_d    = ma_ctrl_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!VALID_EX) begin
               ma_we_d   = 1'b0;
               ma_ctrl_d = '0;
            end else if (is_mem_op(CTRL_EX)) begin
               hold_idx_d   = DEST_REG_INDEX_EX;
               hold_we_d    = DEST_REG_WRITE_EN_EX;
               hold_res_d   = RES_EX;
               hold_wdata_d = STORE_DATA_EX;
               hold_ctrl_d  = CTRL_EX;
               ma_we_d      = 1'b0;
               ma_ctrl_d    = '0;
               state_d      = WAIT;
            end else begin
               ma_idx_d  = DEST_REG_INDEX_EX;
               ma_we_d   = DEST_REG_WRITE_EN_EX;
               ma_res_d  = RES_EX;
               ma_data_d = '0;
               ma_ctrl_d = CTRL_EX;
            end
         end

         WAIT: begin
            // Ack is tested first so it wins over a coincident timeout.
            if (mem.MEM_ACK) begin
               ma_idx_d  = hold_idx_q;
               ma_res_d  = hold_res_q;
               ma_ctrl_d = hold_ctrl_q;
               if (hold_ctrl_q == LOAD) begin
                  ma_we_d   = hold_we_q;
                  ma_data_d = mem.MEM_RDATA;
               end else begin
                  ma_we_d   = 1'b0;
                  ma_data_d = '0;
               end
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               // Aborted instruction retires without writing the register file.
               ma_idx_d  = hold_idx_q;
               ma_res_d  = hold_res_q;
               ma_ctrl_d = hold_ctrl_q;
               ma_we_d   = 1'b0;
               ma_data_d = '0;
               err_d     = 1'b1;
               cnt_d     = '0;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Request and stall are decoded from state so reset removes them at once.
   assign STALL_MA      = (state_q == WAIT);
   assign mem.MEM_REQ   = (state_q == WAIT);
   assign mem.MEM_WE    = (hold_ctrl_q == STORE);
   assign mem.MEM_ADDR  = hold_res_q;
   assign mem.MEM_WDATA = hold_wdata_q;

   assign MEM_ERR              = err_q;
   assign DEST_REG_INDEX_MA    = ma_idx_q;
   assign DEST_REG_WRITE_EN_MA = ma_we_q;
   assign RES_MA               = ma_res_q;
   assign DATA_MA              = ma_data_q;
   assign CTRL_MA              = ma_ctrl_q;
   assign state_dbg            = state_q;

endmodule

// File: tb/tb_memory_access_stage.sv
module tb_memory_access_stage;
  import pipeline_pkg::*;

  localparam int DATA_W = 16;
  localparam logic [4:0] ADD = 5'b00001;

  logic              clk;
  logic              rst;
  logic              valid_ex;
  logic [4:0]        idx_ex;
  logic              we_ex;
  logic [DATA_W-1:0] res_ex;
  logic [DATA_W-1:0] sdata_ex;
  logic [4:0]        ctrl_ex;
  logic              stall_ma;
  logic              mem_err;
  logic [4:0]        idx_ma;
  logic              we_ma;
  logic [DATA_W-1:0] res_ma;
  logic [DATA_W-1:0] data_ma;
  logic [4:0]        ctrl_ma;
  ma_state_t         state_dbg;

  int checks;
  int fails;

  memory_access_stage_if #(.DATA_W(DATA_W)) mem_bus ();

  memory_access_stage #(
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .VALID_EX(valid_ex),
    .DEST_REG_INDEX_EX(idx_ex),
    .DEST_REG_WRITE_EN_EX(we_ex),
    .RES_EX(res_ex),
    .STORE_DATA_EX(sdata_ex),
    .CTRL_EX(ctrl_ex),
    .STALL_MA(stall_ma),
    .mem(mem_bus.master),
    .MEM_ERR(mem_err),
    .DEST_REG_INDEX_MA(idx_ma),
    .DEST_REG_WRITE_EN_MA(we_ma),
    .RES_MA(res_ma),
    .DATA_MA(data_ma),
    .CTRL_MA(ctrl_ma),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [4:0] idx, input logic we,
                          input logic [15:0] res, input logic [15:0] sd,
                          input logic [4:0] ctrl);
    valid_ex = v; idx_ex = idx; we_ex = we; res_ex = res; sdata_ex = sd; ctrl_ex = ctrl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_ex(1'b0, 5'd0, 1'b0, 16'h0, 16'h0, 5'd0);
    mem_bus.MEM_ACK = 1'b0;
    mem_bus.MEM_RDATA = '0;
    step();
    step();
    checks++;
    if ({stall_ma, mem_bus.MEM_REQ, mem_bus.MEM_WE, mem_err, we_ma} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {stall_ma, mem_bus.MEM_REQ, mem_bus.MEM_WE, mem_err, we_ma});
    end
    checks++;
    if ({idx_ma, res_ma, data_ma, ctrl_ma, mem_bus.MEM_ADDR, mem_bus.MEM_WDATA} !== '0) begin
      fails++;
      $display("FAIL reset_data: idx %h res %h data %h ctrl %h addr %h wdata %h expected all 0",
               idx_ma, res_ma, data_ma, ctrl_ma, mem_bus.MEM_ADDR, mem_bus.MEM_WDATA);
    end
    #3 rst = 1'b0;
    step();
  endtask

  task automatic test_alu();
    drive_ex(1'b1, 5'd3, 1'b1, 16'h1234, 16'h5555, ADD);
    step();
    checks++;
    if ({idx_ma, we_ma, res_ma, data_ma, ctrl_ma} !== {5'd3, 1'b1, 16'h1234, 16'h0, ADD}) begin
      fails++;
      $display("FAIL alu_ma: idx %h we %b res %h data %h ctrl %h expected 03 1 1234 0000 01",
               idx_ma, we_ma, res_ma, data_ma, ctrl_ma);
    end
    checks++;
    if ({stall_ma, mem_bus.MEM_REQ} !== 2'b00) begin
      fails++;
      $display("FAIL alu_stall: stall %b req %b expected 0 0", stall_ma, mem_bus.MEM_REQ);
    end
    // second instruction directly behind: one per cycle
    drive_ex(1'b1, 5'd12, 1'b0, 16'hA5A5, 16'h0, 5'b00010);
    step();
    checks++;
    if ({idx_ma, we_ma, res_ma, ctrl_ma} !== {5'd12, 1'b0, 16'hA5A5, 5'b00010}) begin
      fails++;
      $display("FAIL alu_back_to_back: idx %h we %b res %h ctrl %h expected 0c 0 a5a5 02",
               idx_ma, we_ma, res_ma, ctrl_ma);
    end
    // bubble keeps idx/res/data
    drive_ex(1'b0, 5'd31, 1'b1, 16'hFFFF, 16'hFFFF, ADD);
    step();
    checks++;
    if ({idx_ma, we_ma, res_ma, data_ma, ctrl_ma} !== {5'd12, 1'b0, 16'hA5A5, 16'h0, 5'b0}) begin
      fails++;
      $display("FAIL bubble: idx %h we %b res %h data %h ctrl %h expected 0c 0 a5a5 0000 00",
               idx_ma, we_ma, res_ma, data_ma, ctrl_ma);
    end
  endtask

  task automatic test_load();
    int req_cycles;
    drive_ex(1'b1, 5'd5, 1'b1, 16'h0040, 16'h9999, LOAD);
    step();
    drive_ex(1'b0, 5'd0, 1'b0, 16'h0, 16'h0, 5'd0);
    checks++;
    if ({we_ma, ctrl_ma} !== 6'b0) begin
      fails++;
      $display("FAIL load_bubble: we %b ctrl %h expected 0 00", we_ma, ctrl_ma);
    end
    req_cycles = 0;
    for (int c = 1; c <= 3; c++) begin
      if (mem_bus.MEM_REQ === 1'b1) req_cycles++;
      checks++;
      if ({stall_ma, mem_bus.MEM_WE, mem_bus.MEM_ADDR} !== {1'b1, 1'b0, 16'h0040} ||
          state_dbg !== WAIT) begin
        fails++;
        $display("FAIL load_wait_c%0d: stall %b we %b addr %h state %0d expected 1 0 0040 1",
                 c, stall_ma, mem_bus.MEM_WE, mem_bus.MEM_ADDR, state_dbg);
      end
      if (c == 3) begin
        mem_bus.MEM_ACK = 1'b1;
        mem_bus.MEM_RDATA = 16'hBEEF;
      end
      step();
    end
    mem_bus.MEM_ACK = 1'b0;
    mem_bus.MEM_RDATA = 16'h0;
    checks++;
    if (req_cycles !== 3 || mem_bus.MEM_REQ !== 1'b0 || stall_ma !== 1'b0) begin
      fails++;
      $display("FAIL load_req: req_cycles %0d req %b stall %b expected 3 0 0",
               req_cycles, mem_bus.MEM_REQ, stall_ma);
    end
    checks++;
    if ({idx_ma, we_ma, res_ma, data_ma, ctrl_ma} !== {5'd5, 1'b1, 16'h0040, 16'hBEEF, LOAD}) begin
      fails++;
      $display("FAIL load_ma: idx %h we %b res %h data %h ctrl %h expected 05 1 0040 beef 0c",
               idx_ma, we_ma, res_ma, data_ma, ctrl_ma);
    end
  endtask

  task automatic test_store_back_to_back();
    drive_ex(1'b1, 5'd7, 1'b1, 16'h0010, 16'h00AA, STORE);
    step();
    checks++;
    if ({mem_bus.MEM_REQ, mem_bus.MEM_WE, mem_bus.MEM_ADDR, mem_bus.MEM_WDATA} !==
        {1'b1, 1'b1, 16'h0010, 16'h00AA}) begin
      fails++;
      $display("FAIL store_req: req %b we %b addr %h wdata %h expected 1 1 0010 00aa",
               mem_bus.MEM_REQ, mem_bus.MEM_WE, mem_bus.MEM_ADDR, mem_bus.MEM_WDATA);
    end
    // zero-wait ack; EX already presents the next ADD, which must wait
    mem_bus.MEM_ACK = 1'b1;
    drive_ex(1'b1, 5'd9, 1'b1, 16'h0777, 16'h0, ADD);
    step();
    mem_bus.MEM_ACK = 1'b0;
    checks++;
    if ({idx_ma, we_ma, res_ma, data_ma, ctrl_ma, stall_ma} !==
        {5'd7, 1'b0, 16'h0010, 16'h0, STORE, 1'b0}) begin
      fails++;
      $display("FAIL store_ma: idx %h we %b res %h data %h ctrl %h stall %b expected 07 0 0010 0000 0d 0",
               idx_ma, we_ma, res_ma, data_ma, ctrl_ma, stall_ma);
    end
    step();
    drive_ex(1'b0, 5'd0, 1'b0, 16'h0, 16'h0, 5'd0);
    checks++;
    if ({idx_ma, we_ma, res_ma, ctrl_ma} !== {5'd9, 1'b1, 16'h0777, ADD}) begin
      fails++;
      $display("FAIL store_next_add: idx %h we %b res %h ctrl %h expected 09 1 0777 01",
               idx_ma, we_ma, res_ma, ctrl_ma);
    end
  endtask

  task automatic test_ack_at_limit();
    drive_ex(1'b1, 5'd6, 1'b1, 16'h0020, 16'h0, LOAD);
    step();
    drive_ex(1'b0, 5'd0, 1'b0, 16'h0, 16'h0, 5'd0);
    step(); step(); step();
    checks++;
    if (mem_bus.MEM_REQ !== 1'b1) begin
      fails++;
      $display("FAIL limit_req_w4: req %b expected 1", mem_bus.MEM_REQ);
    end
    mem_bus.MEM_ACK = 1'b1;
    mem_bus.MEM_RDATA = 16'h1357;
    step();
    mem_bus.MEM_ACK = 1'b0;
    mem_bus.MEM_RDATA = 16'h0;
    checks++;
    if ({mem_err, mem_bus.MEM_REQ, we_ma, data_ma, idx_ma} !== {1'b0, 1'b0, 1'b1, 16'h1357, 5'd6}) begin
      fails++;
      $display("FAIL limit_ack_wins: err %b req %b we %b data %h idx %h expected 0 0 1 1357 06",
               mem_err, mem_bus.MEM_REQ, we_ma, data_ma, idx_ma);
    end
  endtask

  task automatic test_timeout();
    int req_cycles;
    drive_ex(1'b1, 5'd4, 1'b1, 16'h0080, 16'h0, LOAD);
    step();
    drive_ex(1'b0, 5'd0, 1'b0, 16'h0, 16'h0, 5'd0);
    req_cycles = 0;
    for (int c = 0; c < 10 && mem_bus.MEM_REQ === 1'b1; c++) begin
      req_cycles++;
      step();
    end
    checks++;
    if (req_cycles !== 4) begin
      fails++;
      $display("FAIL timeout_req_cycles: got %0d expected 4", req_cycles);
    end
    checks++;
    if ({mem_err, we_ma, stall_ma, res_ma} !== {1'b1, 1'b0, 1'b0, 16'h0080}) begin
      fails++;
      $display("FAIL timeout_retire: err %b we %b stall %b res %h expected 1 0 0 0080",
               mem_err, we_ma, stall_ma, res_ma);
    end
    // error is sticky across later work and stray acks
    drive_ex(1'b1, 5'd1, 1'b1, 16'h0101, 16'h0, ADD);
    mem_bus.MEM_ACK = 1'b1;
    step();
    mem_bus.MEM_ACK = 1'b0;
    drive_ex(1'b0, 5'd0, 1'b0, 16'h0, 16'h0, 5'd0);
    step();
    checks++;
    if ({mem_err, mem_bus.MEM_REQ, res_ma} !== {1'b1, 1'b0, 16'h0101}) begin
      fails++;
      $display("FAIL timeout_sticky: err %b req %b res %h expected 1 0 0101",
               mem_err, mem_bus.MEM_REQ, res_ma);
    end
  endtask

  task automatic test_reset_mid();
    drive_ex(1'b1, 5'd8, 1'b1, 16'h0030, 16'h0, LOAD);
    step();
    drive_ex(1'b0, 5'd0, 1'b0, 16'h0, 16'h0, 5'd0);
    step();
    checks++;
    if (mem_bus.MEM_REQ !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_pre: req %b expected 1", mem_bus.MEM_REQ);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_bus.MEM_REQ, stall_ma, mem_err, we_ma, idx_ma, res_ma, data_ma, ctrl_ma} !== '0) begin
      fails++;
      $display("FAIL rst_mid_async: req %b stall %b err %b we %b idx %h res %h data %h ctrl %h expected all 0",
               mem_bus.MEM_REQ, stall_ma, mem_err, we_ma, idx_ma, res_ma, data_ma, ctrl_ma);
    end
    #2 rst = 1'b0;
    mem_bus.MEM_ACK = 1'b1;
    mem_bus.MEM_RDATA = 16'hFFFF;
    step();
    mem_bus.MEM_ACK = 1'b0;
    step();
    checks++;
    if ({mem_bus.MEM_REQ, stall_ma, we_ma, data_ma, ctrl_ma, res_ma} !== '0) begin
      fails++;
      $display("FAIL rst_stray_ack: req %b stall %b we %b data %h ctrl %h res %h expected all 0",
               mem_bus.MEM_REQ, stall_ma, we_ma, data_ma, ctrl_ma, res_ma);
    end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    test_reset();
    test_alu();
    test_load();
    test_store_back_to_back();
    test_ack_at_limit();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory-access (MA) stage of the 16-bit pipelined core, sitting between execute (EX) and register write-back. It registers each instruction from EX into the MA pipeline register. Loads and stores run a request/acknowledge transaction to data memory and stall EX until the transaction completes. Its outputs are the `*_MA` bundle consumed by write-back: destination index, write enable, ALU result, load data and control.

## Interface

Parameters:
- `DATA_W`, 16: data and address width.
- `TIMEOUT_CYCLES`, 255: WAIT cycles without `MEM_ACK` before abort. Legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `VALID_EX`  in  1  EX presents an instruction this cycle.
- `DEST_REG_INDEX_EX`  in  5  destination register.
- `DEST_REG_WRITE_EN_EX`  in  1  instruction writes the register file.
- `RES_EX`  in  DATA_W  ALU result; this is the word address for load/store.
- `STORE_DATA_EX`  in  DATA_W  store data.
- `CTRL_EX`  in  5  opcode/control.
- `STALL_MA`  out  1  EX must hold its outputs.
- `MEM_REQ`  out  1  memory request.
- `MEM_WE`  out  1  1 = store, 0 = load.
- `MEM_ADDR`  out  DATA_W  request address.
- `MEM_WDATA`  out  DATA_W  store data.
- `MEM_RDATA`  in  DATA_W  load data; valid in the `MEM_ACK` cycle.
- `MEM_ACK`  in  1  one-cycle completion pulse.
- `MEM_ERR`  out  1  sticky timeout flag.
- `DEST_REG_INDEX_MA`  out  5  registered to write-back.
- `DEST_REG_WRITE_EN_MA`  out  1  registered to write-back.
- `RES_MA`  out  DATA_W  registered to write-back.
- `DATA_MA`  out  DATA_W  registered to write-back.
- `CTRL_MA`  out  5  registered to write-back.

## Operation

- Opcodes: `LOAD = 5'b01100`, `STORE = 5'b01101`. Every other opcode is a non-memory instruction.
- Reset value of every output is 0. Reset puts the FSM in IDLE and clears the timeout counter.
- Bubble: `DEST_REG_WRITE_EN_MA = 0`, `CTRL_MA = 0`; all other `*_MA` outputs retain their previous values.

IDLE state:
- `STALL_MA = 0`.
- `VALID_EX = 0`: load a bubble.
- Valid non-memory instruction: register the EX fields into `*_MA`, with `DATA_MA = 0`.
- Valid LOAD or STORE:
  - Capture index, write enable, `RES_EX`, `STORE_DATA_EX` and `CTRL_EX` into holding registers.
  - Drive `MEM_ADDR = RES_EX`, `MEM_WDATA = STORE_DATA_EX`, `MEM_WE = (CTRL_EX == STORE)`.
  - Set `MEM_REQ = 1`, load a bubble, go to WAIT.

WAIT state:
- `STALL_MA = 1`.
- `MEM_REQ`, `MEM_WE`, `MEM_ADDR` and `MEM_WDATA` stay stable. The counter increments each cycle without `MEM_ACK`.
- On `MEM_ACK = 1`:
  - Clear `MEM_REQ`.
  - Load the held fields into `*_MA`.
  - LOAD: `DATA_MA = MEM_RDATA`.
  - STORE: `DATA_MA = 0` and `DEST_REG_WRITE_EN_MA = 0`.
  - Go to IDLE.
- When the counter reaches `TIMEOUT_CYCLES` without an ack:
  - Clear `MEM_REQ`, set `MEM_ERR = 1`.
  - Retire the instruction with `DEST_REG_WRITE_EN_MA = 0`.
  - Go to IDLE.
- `MEM_ACK` and timeout in the same cycle: the ack wins; no error.

Other rules:
- `MEM_ACK` in IDLE is ignored.
- `MEM_ERR` is cleared only by `rst`.
- Reset mid-transaction: `MEM_REQ` drops immediately (asynchronously) and the held instruction is discarded.

## Timing

- Non-memory instruction: accepted at edge t, visible on `*_MA` in cycle t+1. Throughput is one instruction per cycle.
- Memory instruction: accepted at edge t. `MEM_REQ` is high from cycle t+1. With the ack in cycle t+k (k ≥ 1), the result is on `*_MA` in cycle t+k+1.
- Zero-wait memory (ack in the first REQ cycle) gives 2-cycle latency.
- `STALL_MA` is decoded from state (high in WAIT). The next EX instruction is accepted at the edge ending cycle t+k+1 at the earliest, so a memory op occupies the stage for k+1 cycles.
- While `STALL_MA = 1`, `VALID_EX` and the EX fields are ignored; EX holds them.

## Structure

- Shared package `pipeline_pkg` holds:
  - `LOAD` and `STORE` opcodes;
  - `REG_IDX_W = 5`, `CTRL_W = 5`;
  - the `ma_state_t` enum {IDLE, WAIT}.
- Single module with no sub-modules.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`, inline.

## Test plan

- Reset, then ADD (ctrl `5'b00001`, idx 3, we 1, res `0x1234`) → next cycle `*_MA` = idx 3, we 1, `RES_MA = 0x1234`, `DATA_MA = 0`; `STALL_MA` stays 0.
- LOAD addr `0x0040`, memory acks 3 cycles after REQ with `0xBEEF` → `MEM_REQ` high for 3 cycles with stable addr and `MEM_WE = 0`; `DATA_MA = 0xBEEF`, `WRITE_EN_MA = 1` the cycle after the ack; `STALL_MA` high throughout WAIT.
- STORE addr `0x0010`, data `0x00AA`, zero-wait ack → `MEM_WE = 1`, `MEM_WDATA = 0x00AA`; retires with `WRITE_EN_MA = 0`; a following ADD is accepted the next cycle.
- LOAD with `TIMEOUT_CYCLES = 4` and no ack → `MEM_REQ` drops after 4 WAIT cycles; `MEM_ERR = 1` and stays 1; instruction retires with we 0. Repeat with the ack in the 4th WAIT cycle → no error, data taken.
- Assert `rst` in the 2nd WAIT cycle of a LOAD → `MEM_REQ`, `STALL_MA` and all `*_MA` outputs go to 0 immediately; a stray `MEM_ACK` after reset has no effect.
